// File: rtl/alu_pipe_nbit.sv
// Multi-cycle ALU: add/sub/logic/slt in one EXEC cycle, unsigned shift-add multiply over WIDTH cycles.
// Latency: out_valid seen 2 edges after accept for single-cycle ops, WIDTH+2 for multiply.
// Backpressure: one command in flight; in_ready only in IDLE, result held in DONE until out_ready.
module alu_pipe_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             alu_op,
  input  logic [4:0]       functop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             borrow_out,
  output logic             zero,
  output logic             overflow,
  output logic             err
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_MUL = 3'd6,
    OP_ILL = 3'd7
  } op_t;

  state_t             state_q, state_d;
  op_t                op_q, op_d, op_dec;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               borrow_q, borrow_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  logic               accept;
  logic [WIDTH:0]     add_w, sub_w;
  logic               slt;
  logic [WIDTH-1:0]   exec_res;
  logic               exec_c, exec_b, exec_o, exec_e;

  // in_ready is held low while reset is asserted so a command on the reset edge is never taken
  assign in_ready  = (state_q == S_IDLE) && rst_n;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);

  assign result     = result_q;
  assign carry_out  = carry_q;
  assign borrow_out = borrow_q;
  assign zero       = zero_q;
  assign overflow   = ovf_q;
  assign err        = err_q;

  // Extra MSB on the add/sub gives carry-out and unsigned borrow directly
  assign add_w = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w = {1'b0, a_q} - {1'b0, b_q};
  assign slt   = ($signed(a_q) < $signed(b_q));

  // Opcode decode of the live inputs; alu_op=0 forces ADD whatever functop holds
  always_comb begin
    op_dec = OP_ILL;
    if (!alu_op) begin
      op_dec = OP_ADD;
    end else begin
      case (functop)
        5'b01000: op_dec = OP_ADD;
        5'b00100: op_dec = OP_SUB;
        5'b00000: op_dec = OP_AND;
        5'b11000: op_dec = OP_OR;
        5'b10000: op_dec = OP_XOR;
        5'b01100: op_dec = OP_SLT;
        5'b00010: op_dec = OP_MUL;
        default:  op_dec = OP_ILL;
      endcase
    end
  end

  // Single-cycle result and flags from the latched operands; undefined flags stay 0
  always_comb begin
    exec_res = '0;
    exec_c   = 1'b0;
    exec_b   = 1'b0;
    exec_o   = 1'b0;
    exec_e   = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_res = add_w[WIDTH-1:0];
        exec_c   = add_w[WIDTH];
        exec_o   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        exec_res = sub_w[WIDTH-1:0];
        exec_b   = sub_w[WIDTH];
        exec_o   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: exec_res = a_q & b_q;
      OP_OR:  exec_res = a_q | b_q;
      OP_XOR: exec_res = a_q ^ b_q;
      OP_SLT: exec_res = {{(WIDTH-1){1'b0}}, slt};
      default: begin
        // OP_ILL (OP_MUL never reaches EXEC)
        exec_res = '0;
        exec_e   = 1'b1;
      end
    endcase
  end

  // Next-state logic for the control FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (op_dec == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: state_d = S_DONE;
      S_MUL: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next state: latch on accept, write outputs at end of EXEC or after the last MUL step
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op_dec;
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          mcand_d = {{WIDTH{1'b0}}, a};
          mplr_d  = b;
          cnt_d   = '0;
        end
      end
      S_EXEC: begin
        result_d = exec_res;
        carry_d  = exec_c;
        borrow_d = exec_b;
        ovf_d    = exec_o;
        err_d    = exec_e;
        zero_d   = (exec_res == '0);
      end
      S_MUL: begin
        if (cnt_q != CNT_LAST) begin
          // One partial product per cycle: add shifted multiplicand when the multiplier LSB is set
          if (mplr_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          result_d = acc_q[WIDTH-1:0];
          carry_d  = |acc_q[2*WIDTH-1:WIDTH];
          borrow_d = 1'b0;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          zero_d   = (acc_q[WIDTH-1:0] == '0);
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe_nbit.sv
// Directed bench for alu_pipe_nbit at WIDTH=8.
// Inputs driven and outputs sampled on the falling edge.
// Flags compared as {carry_out, borrow_out, zero, overflow, err}.
module tb_alu_pipe_nbit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       alu_op;
  logic [4:0] functop;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry_out;
  logic       borrow_out;
  logic       zero;
  logic       overflow;
  logic       err;
  logic [4:0] flags;

  int vectors;
  int miscompares;

  assign flags = {carry_out, borrow_out, zero, overflow, err};

  alu_pipe_nbit #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .alu_op     (alu_op),
    .functop    (functop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry_out  (carry_out),
    .borrow_out (borrow_out),
    .zero       (zero),
    .overflow   (overflow),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the directed sequence itself gets stuck
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command at a falling edge, drop it after the accept edge,
  // then count falling edges until out_valid is seen (bounded).
  task automatic run_op(input logic op, input logic [4:0] fop, input logic [7:0] av,
                        input logic [7:0] bv, output int lat, output int rdy_bad);
    alu_op   = op;
    functop  = fop;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    rdy_bad  = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_bad++;
      @(negedge clk);
      lat++;
    end
    if (in_ready) rdy_bad++;
  endtask

  task automatic done_ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_vec(input string tag, input logic op, input logic [4:0] fop,
                        input logic [7:0] av, input logic [7:0] bv, input logic [7:0] er,
                        input logic [4:0] ef, input int elat, input bit ack);
    int lat;
    int rdy_bad;
    run_op(op, fop, av, bv, lat, rdy_bad);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_res"}, result, er);
    chk({tag, "_flg"}, flags, ef);
    chk({tag, "_busy"}, rdy_bad, 0);
    if (ack) done_ack();
  endtask

  initial begin
    int stab_bad;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    alu_op      = 1'b0;
    functop     = 5'd0;
    a           = 8'd0;
    b           = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_res", result, 8'h00);
    chk("rst_flg", flags, 5'b00000);
    chk("rst_ovld", out_valid, 1'b0);
    chk("rst_irdy_low", in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rst_irdy_rel", in_ready, 1'b1);
    @(negedge clk);

    // Single-cycle ops                 op    funct     a      b      result  c b z o e   lat
    do_vec("add_ff_01", 1'b1, 5'b01000, 8'hFF, 8'h01, 8'h00, 5'b10100, 2, 1'b1);
    do_vec("sub_10_20", 1'b1, 5'b00100, 8'h10, 8'h20, 8'hF0, 5'b01000, 2, 1'b1);
    do_vec("sub_80_01", 1'b1, 5'b00100, 8'h80, 8'h01, 8'h7F, 5'b00010, 2, 1'b1);
    do_vec("force_add", 1'b0, 5'b11111, 8'h03, 8'h02, 8'h05, 5'b00000, 2, 1'b1);
    do_vec("ill_11111", 1'b1, 5'b11111, 8'h03, 8'h02, 8'h00, 5'b00101, 2, 1'b1);
    do_vec("ill_00001", 1'b1, 5'b00001, 8'hAB, 8'hCD, 8'h00, 5'b00101, 2, 1'b1);
    do_vec("or_f0_0f",  1'b1, 5'b11000, 8'hF0, 8'h0F, 8'hFF, 5'b00000, 2, 1'b1);
    do_vec("xor_aa_aa", 1'b1, 5'b10000, 8'hAA, 8'hAA, 8'h00, 5'b00100, 2, 1'b1);
    do_vec("slt_80_01", 1'b1, 5'b01100, 8'h80, 8'h01, 8'h01, 5'b00000, 2, 1'b1);
    do_vec("slt_01_80", 1'b1, 5'b01100, 8'h01, 8'h80, 8'h00, 5'b00100, 2, 1'b1);

    // out_ready already high when DONE is entered: one-cycle out_valid
    out_ready = 1'b1;
    do_vec("and_f0_3c", 1'b1, 5'b00000, 8'hF0, 8'h3C, 8'h30, 5'b00000, 2, 1'b0);
    @(negedge clk);
    chk("rdy_hi_ovld", out_valid, 1'b0);
    chk("rdy_hi_irdy", in_ready, 1'b1);
    out_ready = 1'b0;

    // Backpressure: hold result while a new command waits
    do_vec("add_7f_01", 1'b1, 5'b01000, 8'h7F, 8'h01, 8'h80, 5'b00010, 2, 1'b0);
    alu_op   = 1'b0;
    functop  = 5'b00000;
    a        = 8'h01;
    b        = 8'h02;
    in_valid = 1'b1;
    stab_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (result !== 8'h80 || flags !== 5'b00010 || in_ready !== 1'b0 || out_valid !== 1'b1)
        stab_bad++;
    end
    chk("bp_stable", stab_bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_irdy", in_ready, 1'b1);
    chk("bp_idle_ovld", out_valid, 1'b0);
    chk("bp_idle_hold", result, 8'h80);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_exec_irdy", in_ready, 1'b0);
    @(negedge clk);
    chk("bp_new_ovld", out_valid, 1'b1);
    chk("bp_new_res", result, 8'h03);
    chk("bp_new_flg", flags, 5'b00000);
    done_ack();

    // Multiply
    do_vec("mul_0f_0f", 1'b1, 5'b00010, 8'h0F, 8'h0F, 8'hE1, 5'b00000, 10, 1'b1);
    do_vec("mul_10_11", 1'b1, 5'b00010, 8'h10, 8'h11, 8'h10, 5'b10000, 10, 1'b1);

    // Reset during multiply iteration 4, with a command present on the reset edge
    alu_op   = 1'b1;
    functop  = 5'b00010;
    a        = 8'hFF;
    b        = 8'hFF;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n    = 1'b0;
    alu_op   = 1'b0;
    a        = 8'h05;
    b        = 8'h05;
    in_valid = 1'b1;
    @(negedge clk);
    chk("mrst_res", result, 8'h00);
    chk("mrst_flg", flags, 5'b00000);
    chk("mrst_ovld", out_valid, 1'b0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("mrst_irdy", in_ready, 1'b1);
    @(negedge clk);
    chk("mrst_discard_irdy", in_ready, 1'b1);
    chk("mrst_discard_ovld", out_valid, 1'b0);
    do_vec("add_01_01", 1'b1, 5'b01000, 8'h01, 8'h01, 8'h02, 5'b00000, 2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
